// File: rtl/data_bus_if.sv
// Bridges the single-cycle CPU memory request to a Wishbone-classic bus: holds the
// request until ack, stalls the pipeline meanwhile, and buffers read data under stall.
module data_bus_if #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int STALL_BIT = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          stall_i,
    input  logic                flush_i,
    input  logic                cpu_ce_i,
    input  logic                cpu_we_i,
    input  logic [ADDR_W-1:0]   cpu_addr_i,
    input  logic [DATA_W/8-1:0] cpu_sel_i,
    input  logic [DATA_W-1:0]   cpu_data_i,
    output logic [DATA_W-1:0]   cpu_data_o,
    output logic                stallreq_o,
    output logic                bus_err_o,
    output logic                bus_cyc_o,
    output logic                bus_stb_o,
    output logic                bus_we_o,
    output logic [ADDR_W-1:0]   bus_adr_o,
    output logic [DATA_W/8-1:0] bus_sel_o,
    output logic [DATA_W-1:0]   bus_dat_o,
    input  logic [DATA_W-1:0]   bus_dat_i,
    input  logic                bus_ack_i
);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_BUSY       = 2'd1,
        S_WAIT_STALL = 2'd2
    } state_e;

    localparam bit         TO_EN   = (TIMEOUT != 0);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_e                state_q;
    logic [7:0]            cnt_q;
    logic [DATA_W-1:0]     rd_buf_q;
    logic                  cyc_q;
    logic                  stb_q;
    logic                  we_q;
    logic                  err_q;
    logic [ADDR_W-1:0]     adr_q;
    logic [DATA_W/8-1:0]   sel_q;
    logic [DATA_W-1:0]     dat_q;

    logic                  stall_hold;
    logic                  timeout_hit;
    logic                  bus_done;
    logic                  stall_unused;

    assign stall_hold   = stall_i[STALL_BIT];
    // Only the consuming stage's stall bit matters; the rest are deliberately ignored.
    assign stall_unused = ^(stall_i & ~(6'b1 << STALL_BIT));
    assign timeout_hit  = TO_EN && (cnt_q == TO_LAST);
    assign bus_done     = (state_q == S_BUSY) && (flush_i || bus_ack_i || timeout_hit);

    // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        stallreq_o = 1'b0;
        cpu_data_o = '0;
        case (state_q)
            S_IDLE: begin
                stallreq_o = cpu_ce_i & ~flush_i;
            end
            S_BUSY: begin
                stallreq_o = ~bus_ack_i & ~flush_i;
                if (bus_ack_i && !flush_i && !we_q) begin
                    cpu_data_o = bus_dat_i;
                end
            end
            S_WAIT_STALL: begin
                cpu_data_o = rd_buf_q;
            end
            default: begin
                stallreq_o = 1'b0;
            end
        endcase
    end

    // NOTE: state is written with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rd_buf_q <= '0;
            cyc_q    <= 1'b0;
            stb_q    <= 1'b0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            adr_q    <= '0;
            sel_q    <= '0;
            dat_q    <= '0;
        end else begin
            err_q <= 1'b0;

            // Any way out of BUSY returns the bus to its all-zero idle image.
            if (bus_done) begin
                cyc_q <= 1'b0;
                stb_q <= 1'b0;
                we_q  <= 1'b0;
                adr_q <= '0;
                sel_q <= '0;
                dat_q <= '0;
            end

            case (state_q)
                S_IDLE: begin
                    if (cpu_ce_i && !flush_i) begin
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        we_q    <= cpu_we_i;
                        adr_q   <= cpu_addr_i;
                        sel_q   <= cpu_sel_i;
                        dat_q   <= cpu_data_i;
                        cnt_q   <= '0;
                        state_q <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (flush_i) begin
                        state_q <= S_IDLE;
                    end else if (bus_ack_i) begin
                        if (!we_q) begin
                            rd_buf_q <= bus_dat_i;
                        end
                        state_q <= stall_hold ? S_WAIT_STALL : S_IDLE;
                    end else if (timeout_hit) begin
                        err_q    <= 1'b1;
                        rd_buf_q <= '0;
                        state_q  <= S_IDLE;
                    end
                end
                S_WAIT_STALL: begin
                    if (!stall_hold || flush_i) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus_cyc_o = cyc_q;
    assign bus_stb_o = stb_q;
    assign bus_we_o  = we_q;
    assign bus_adr_o = adr_q;
    assign bus_sel_o = sel_q;
    assign bus_dat_o = dat_q;
    assign bus_err_o = err_q;

endmodule
